// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode and carries the control word through ID/EX, EX/MEM and MEM/WB.
// Handles load-use bubbles, memory stalls, decode flush and a halt-drain FSM; PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipe_ctrl_unit #(
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 4,
  parameter int ALUOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] src_a_addr,
  input  logic [REG_ADDR_W-1:0] src_b_addr,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  input  logic                  mem_stall,
  input  logic                  flush,
  output logic                  fetch_stall,
  output logic                  ex_valid,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic                  ex_alusrc,
  output logic                  ex_regdst,
  output logic                  ex_pcs,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_half,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  halted,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  logic [3:0]         op4;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_alusrc, dec_regdst, dec_pcs;
  logic               dec_memread, dec_memwrite, dec_half;
  logic               dec_regwrite, dec_memtoreg, dec_halt;
  logic               use_a, use_b;

  logic                  ex_memread, ex_memwrite, ex_half;
  logic                  ex_regwrite, ex_memtoreg, ex_halt;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  mem_regwrite, mem_memtoreg, mem_halt;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  wb_halt;

  logic hz;
  logic load_id;
  logic hlt_accept;

  assign op4 = opcode[OPCODE_W-1 -: 4];

  always_comb begin
    dec_aluop    = '0;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_pcs      = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_half     = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_halt     = 1'b0;
    use_a        = 1'b0;
    use_b        = 1'b0;
    if (!op4[3]) begin
      dec_aluop    = ALUOP_W'(op4[2:0]);
      dec_regdst   = 1'b1;
      dec_regwrite = 1'b1;
      // 0100-0110 take an immediate as the second operand
      dec_alusrc   = (op4[2:0] == 3'd4) || (op4[2:0] == 3'd5) || (op4[2:0] == 3'd6);
      use_a        = 1'b1;
      use_b        = !op4[2] || (op4[2:0] == 3'd7);
    end else begin
      case (op4[2:0])
        3'd0: begin
          dec_memread  = 1'b1;
          dec_memtoreg = 1'b1;
          dec_regwrite = 1'b1;
          use_a        = 1'b1;
        end
        3'd1: begin
          dec_memwrite = 1'b1;
          use_a        = 1'b1;
          use_b        = 1'b1;
        end
        3'd2: begin
          dec_regwrite = 1'b1;
          use_a        = 1'b1;
        end
        3'd3: begin
          dec_regwrite = 1'b1;
          dec_half     = 1'b1;
          use_a        = 1'b1;
        end
        3'd4: ;
        3'd5: use_a = 1'b1;
        3'd6: begin
          dec_pcs      = 1'b1;
          dec_regwrite = 1'b1;
        end
        3'd7: dec_halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign hz = ex_valid & ex_memread & id_valid &
              (((ex_dst == src_a_addr) & use_a) | ((ex_dst == src_b_addr) & use_b));

  // Stage valid/stall semantics: a stage register holds whenever mem_stall is high; otherwise
  // every stage advances each cycle and ID/EX takes the decoded word only when load_id is high
  // (RUN, no flush, no hazard, id_valid). fetch_stall tells IF to hold the IF/ID contents.
  assign load_id     = (state == RUN) & ~flush & ~hz & id_valid;
  assign hlt_accept  = load_id & dec_halt & ~mem_stall;
  assign fetch_stall = mem_stall | (state != RUN) | (hz & ~flush);
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_aluop     <= '0;
      ex_alusrc    <= 1'b0;
      ex_regdst    <= 1'b0;
      ex_pcs       <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_half      <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_halt      <= 1'b0;
      ex_dst       <= '0;
      mem_valid    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_half     <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_halt     <= 1'b0;
      mem_dst      <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_halt      <= 1'b0;
      wb_dst       <= '0;
    end else if (!mem_stall) begin
      if (load_id) begin
        ex_valid    <= 1'b1;
        ex_aluop    <= dec_aluop;
        ex_alusrc   <= dec_alusrc;
        ex_regdst   <= dec_regdst;
        ex_pcs      <= dec_pcs;
        ex_memread  <= dec_memread;
        ex_memwrite <= dec_memwrite;
        ex_half     <= dec_half;
        ex_regwrite <= dec_regwrite;
        ex_memtoreg <= dec_memtoreg;
        ex_halt     <= dec_halt;
        ex_dst      <= dst_addr;
      end else begin
        // bubble: flush, hazard, empty IF/ID, or draining/halted
        ex_valid    <= 1'b0;
        ex_aluop    <= '0;
        ex_alusrc   <= 1'b0;
        ex_regdst   <= 1'b0;
        ex_pcs      <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_half     <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_halt     <= 1'b0;
        ex_dst      <= '0;
      end
      mem_valid    <= ex_valid;
      mem_read     <= ex_memread;
      mem_write    <= ex_memwrite;
      mem_half     <= ex_half;
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_halt     <= ex_halt;
      mem_dst      <= ex_dst;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_halt      <= mem_halt;
      wb_dst       <= mem_dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (!mem_stall) begin
      case (state)
        RUN: begin
          if (hlt_accept) state <= DRAIN;
        end
        DRAIN: begin
          if (wb_valid && wb_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // flush wins over a simultaneous hazard, so that cycle counts only as a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else if (!mem_stall) begin
      if (hz && !flush && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush && id_valid && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
